// File: rtl/fir_stream_scheduler.sv
// Block-rate feeder for the 3-parallel FIR: buffers input blocks, issues one block per clock
// once a frame is ready, flushes the taps with zero tail blocks and tags filter outputs.
module fir_stream_scheduler #(
    parameter int DATA_W       = 32,
    parameter int OUT_W        = 64,
    parameter int DEPTH        = 8,
    parameter int START_THRESH = 4,
    parameter int TAIL_BLOCKS  = 3,
    parameter int FILT_LAT     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_x0,
    input  logic signed [DATA_W-1:0] s_x1,
    input  logic signed [DATA_W-1:0] s_x2,
    input  logic                     s_last,
    output logic signed [DATA_W-1:0] filt_x0,
    output logic signed [DATA_W-1:0] filt_x1,
    output logic signed [DATA_W-1:0] filt_x2,
    input  logic signed [OUT_W-1:0]  filt_y0,
    input  logic signed [OUT_W-1:0]  filt_y1,
    input  logic signed [OUT_W-1:0]  filt_y2,
    output logic                     m_valid,
    output logic                     m_last,
    output logic signed [OUT_W-1:0]  m_y0,
    output logic signed [OUT_W-1:0]  m_y1,
    output logic signed [OUT_W-1:0]  m_y2,
    output logic                     busy,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TAIL_BLOCKS > 1) ? $clog2(TAIL_BLOCKS) : 1;
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH   = LW'(START_THRESH);
    localparam logic [TW-1:0] TAIL_END = TW'(TAIL_BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] x2;
        logic [DATA_W-1:0] x1;
        logic [DATA_W-1:0] x0;
    } blk_t;

    blk_t            mem [DEPTH];
    blk_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count, last_cnt;
    logic            push, pop;
    state_t          state;
    logic [TW-1:0]   tail_cnt;
    logic [FILT_LAT:0] vld_pipe, lst_pipe;

    assign s_ready = (count < FULL);
    assign push    = s_valid && s_ready;
    assign pop     = (state == RUN) && (count != '0);
    assign head    = mem[rd_ptr];
    assign level   = count;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_last, s_x2, s_x1, s_x0};
    end

    // last_cnt lets a short frame start below threshold once its final block is buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: ;
            endcase
            last_cnt <= last_cnt + LW'(push && s_last) - LW'(pop && head.last);
        end
    end

    // vld_pipe[0]/lst_pipe[0] are the issue flags loaded alongside filt_x*
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            filt_x0  <= '0;
            filt_x1  <= '0;
            filt_x2  <= '0;
            underrun <= 1'b0;
            tail_cnt <= '0;
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe[FILT_LAT:1] <= vld_pipe[FILT_LAT-1:0];
            lst_pipe[FILT_LAT:1] <= lst_pipe[FILT_LAT-1:0];
            lst_pipe[0] <= 1'b0;
            filt_x0     <= '0;
            filt_x1     <= '0;
            filt_x2     <= '0;
            case (state)
                IDLE: begin
                    vld_pipe[0] <= 1'b0;
                    if (count >= THRESH || (last_cnt != '0 && count != '0))
                        state <= RUN;
                end
                RUN: begin
                    vld_pipe[0] <= 1'b1;
                    if (count != '0) begin
                        filt_x0 <= $signed(head.x0);
                        filt_x1 <= $signed(head.x1);
                        filt_x2 <= $signed(head.x2);
                        if (head.last) begin
                            state    <= DRAIN;
                            tail_cnt <= '0;
                        end
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    vld_pipe[0] <= 1'b1;
                    if (tail_cnt == TAIL_END) begin
                        lst_pipe[0] <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tail_cnt <= tail_cnt + TW'(1);
                    end
                end
                default: begin
                    vld_pipe[0] <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_y0    <= '0;
            m_y1    <= '0;
            m_y2    <= '0;
        end else begin
            m_valid <= vld_pipe[FILT_LAT];
            m_last  <= lst_pipe[FILT_LAT];
            m_y0    <= filt_y0;
            m_y1    <= filt_y1;
            m_y2    <= filt_y2;
        end
    end
endmodule

// File: tb/tb_fir_stream_scheduler.sv
// Directed bench for fir_stream_scheduler; the FIR is stood in for by a pure FILT_LAT delay
// so every m_y* value maps straight back to the issued block.
module tb_fir_stream_scheduler;
    localparam int DW = 32, OW = 64, LAT = 2;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic signed [DW-1:0] s_x0 = '0, s_x1 = '0, s_x2 = '0, filt_x0, filt_x1, filt_x2;
    logic signed [OW-1:0] filt_y0, filt_y1, filt_y2, m_y0, m_y1, m_y2;
    logic m_valid, m_last, busy, underrun;
    logic [3:0] level;

    logic f_valid = 1'b0, f_last = 1'b0, f_ready;
    logic signed [DW-1:0] f_x0 = '0, f_x1 = '0, f_x2 = '0, f_fx0, f_fx1, f_fx2;
    logic signed [OW-1:0] f_fy0, f_fy1, f_fy2, f_y0, f_y1, f_y2;
    logic f_mvalid, f_mlast, f_busy, f_underrun;
    logic [3:0] f_level;

    fir_stream_scheduler #(.DATA_W(DW), .OUT_W(OW), .DEPTH(8), .START_THRESH(4),
                           .TAIL_BLOCKS(3), .FILT_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_x0(s_x0), .s_x1(s_x1), .s_x2(s_x2), .s_last(s_last),
        .filt_x0(filt_x0), .filt_x1(filt_x1), .filt_x2(filt_x2),
        .filt_y0(filt_y0), .filt_y1(filt_y1), .filt_y2(filt_y2),
        .m_valid(m_valid), .m_last(m_last), .m_y0(m_y0), .m_y1(m_y1), .m_y2(m_y2),
        .busy(busy), .underrun(underrun), .level(level));

    fir_stream_scheduler #(.DATA_W(DW), .OUT_W(OW), .DEPTH(8), .START_THRESH(8),
                           .TAIL_BLOCKS(3), .FILT_LAT(LAT)) u_full (
        .clk(clk), .rst(rst), .s_valid(f_valid), .s_ready(f_ready),
        .s_x0(f_x0), .s_x1(f_x1), .s_x2(f_x2), .s_last(f_last),
        .filt_x0(f_fx0), .filt_x1(f_fx1), .filt_x2(f_fx2),
        .filt_y0(f_fy0), .filt_y1(f_fy1), .filt_y2(f_fy2),
        .m_valid(f_mvalid), .m_last(f_mlast), .m_y0(f_y0), .m_y1(f_y1), .m_y2(f_y2),
        .busy(f_busy), .underrun(f_underrun), .level(f_level));

    logic [LAT-1:0][2:0][DW-1:0] fd = '0, gd = '0;
    always @(posedge clk) begin
        fd <= {fd[LAT-2:0], {filt_x2, filt_x1, filt_x0}};
        gd <= {gd[LAT-2:0], {f_fx2, f_fx1, f_fx0}};
    end
    assign filt_y0 = OW'($signed(fd[LAT-1][0]));
    assign filt_y1 = OW'($signed(fd[LAT-1][1]));
    assign filt_y2 = OW'($signed(fd[LAT-1][2]));
    assign f_fy0   = OW'($signed(gd[LAT-1][0]));
    assign f_fy1   = OW'($signed(gd[LAT-1][1]));
    assign f_fy2   = OW'($signed(gd[LAT-1][2]));

    int n_chk = 0, n_fail = 0;
    longint x0q[$], x1q[$], x2q[$], y0q[$], y1q[$], y2q[$], fyq[$];
    int lq[$], runs[$], rise_q[$], xcq[$];
    int run = 0;
    logic busy_p = 1'b0;

    // an edge whose pre-edge state was RUN/DRAIN is an issue edge
    always @(negedge clk) begin
        if (busy_p) begin
            x0q.push_back(filt_x0); x1q.push_back(filt_x1); x2q.push_back(filt_x2);
            xcq.push_back(cyc);
        end
        busy_p = busy;
        if (m_valid) begin
            if (run == 0) rise_q.push_back(cyc);
            y0q.push_back(m_y0); y1q.push_back(m_y1); y2q.push_back(m_y2);
            lq.push_back(int'(m_last));
            run++;
        end else if (run != 0) begin
            runs.push_back(run);
            run = 0;
        end
        if (f_mvalid) fyq.push_back(f_y0);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        x0q.delete(); x1q.delete(); x2q.delete(); xcq.delete();
        y0q.delete(); y1q.delete(); y2q.delete(); lq.delete();
        runs.delete(); rise_q.delete(); fyq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_blk(input int b, input logic last);
        int n = 0;
        s_valid = 1'b1; s_x0 = b; s_x1 = b + 1; s_x2 = b + 2; s_last = last;
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("push_tmo", n, 0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || level != 0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk({tag, "_tmo"}, n, 0);
        idle(LAT + 4);
    endtask

    // expected base b means block {b,b+1,b+2}; 0 means a zero block
    task automatic chk_seq(input string tag, input int e[$]);
        longint v0, v1, v2;
        chk({tag, "_xn"}, x0q.size(), e.size());
        chk({tag, "_yn"}, y0q.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            v0 = e[i];
            v1 = (e[i] == 0) ? 0 : e[i] + 1;
            v2 = (e[i] == 0) ? 0 : e[i] + 2;
            if (i < x0q.size()) begin
                chk($sformatf("%s_x0[%0d]", tag, i), x0q[i], v0);
                chk($sformatf("%s_x1[%0d]", tag, i), x1q[i], v1);
                chk($sformatf("%s_x2[%0d]", tag, i), x2q[i], v2);
            end
            if (i < y0q.size()) begin
                chk($sformatf("%s_y0[%0d]", tag, i), y0q[i], v0);
                chk($sformatf("%s_y1[%0d]", tag, i), y1q[i], v1);
                chk($sformatf("%s_y2[%0d]", tag, i), y2q[i], v2);
            end
        end
    endtask

    task automatic chk_runs(input string tag, input int e[$]);
        chk({tag, "_nruns"}, runs.size(), e.size());
        for (int i = 0; i < e.size() && i < runs.size(); i++)
            chk($sformatf("%s_run[%0d]", tag, i), runs[i], e[i]);
    endtask

    task automatic chk_last(input string tag, input int pos[$]);
        int ones = 0;
        foreach (lq[i]) ones += lq[i];
        chk({tag, "_nlast"}, ones, pos.size());
        foreach (pos[i])
            chk($sformatf("%s_last@%0d", tag, pos[i]), (pos[i] < lq.size()) ? lq[pos[i]] : -1, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e[$], r[$], p[$];
        int n, idx, bad;
        logic rdy, saw_full;

        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_fx0", filt_x0, 0);
        chk("rst_fx1", filt_x1, 0);
        chk("rst_fx2", filt_x2, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_my0", m_y0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_undr", underrun, 0);
        chk("rst_f_level", f_level, 0);
        rst = 1'b0;
        idle(2);
        clr();

        // basic frame of 6 blocks
        for (int i = 0; i < 6; i++) push_blk(3 * i + 1, i == 5);
        wait_done("t1");
        e = '{1, 4, 7, 10, 13, 16, 0, 0, 0}; chk_seq("t1", e);
        r = '{9}; chk_runs("t1", r);
        p = '{8}; chk_last("t1", p);
        chk("t1_lat", (rise_q.size() > 0 && xcq.size() > 0) ? rise_q[0] - xcq[0] : -1, LAT + 1);
        chk("t1_undr", underrun, 0);
        clr();

        // underrun: FIFO runs dry for two issue slots mid-frame
        for (int i = 0; i < 4; i++) push_blk(21 + 3 * i, 1'b0);
        n = 0;
        while (level != 0 && n < 100) begin @(negedge clk); n++; end
        idle(1);
        push_blk(33, 1'b1);
        wait_done("t2");
        e = '{21, 24, 27, 30, 0, 0, 33, 0, 0, 0}; chk_seq("t2", e);
        r = '{10}; chk_runs("t2", r);
        p = '{9}; chk_last("t2", p);
        chk("t2_undr", underrun, 1);
        clr();

        // reset in RUN with three blocks still buffered
        for (int i = 0; i < 7; i++) push_blk(301 + 3 * i, 1'b0);
        n = 0;
        while (level != 3 && n < 100) begin @(negedge clk); n++; end
        chk("t5_lvl_pre", level, 3);
        chk("t5_busy_pre", busy, 1);
        chk("t5_undr_pre", underrun, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_level", level, 0);
        chk("t5_busy", busy, 0);
        chk("t5_fx0", filt_x0, 0);
        chk("t5_fx1", filt_x1, 0);
        chk("t5_fx2", filt_x2, 0);
        chk("t5_undr", underrun, 0);
        chk("t5_mvalid", m_valid, 0);
        chk("t5_ready", s_ready, 1);
        idle(1);
        clr();
        idle(10);
        chk("t5_nomv", y0q.size(), 0);
        clr();

        // short frame: one block carrying last
        push_blk(5, 1'b1);
        idle(1);
        chk("t4_busy", busy, 1);
        chk("t4_level", level, 1);
        wait_done("t4");
        e = '{5, 0, 0, 0}; chk_seq("t4", e);
        r = '{4}; chk_runs("t4", r);
        p = '{3}; chk_last("t4", p);
        clr();

        // back-to-back 4-block frames
        for (int i = 0; i < 4; i++) push_blk(101 + 3 * i, i == 3);
        for (int i = 0; i < 4; i++) push_blk(201 + 3 * i, i == 3);
        wait_done("t6");
        e = '{101, 104, 107, 110, 0, 0, 0, 201, 204, 207, 210, 0, 0, 0}; chk_seq("t6", e);
        r = '{7, 7}; chk_runs("t6", r);
        p = '{6, 13}; chk_last("t6", p);
        chk("t6_gap", (rise_q.size() >= 2 && runs.size() >= 1) ? rise_q[1] - rise_q[0] - runs[0] : -1, 1);
        clr();

        // full FIFO on the threshold-8 instance, s_valid held high throughout
        idx = 0; n = 0; bad = 0; saw_full = 1'b0;
        while (idx < 16 && n < 300) begin
            f_valid = 1'b1;
            f_x0 = 3 * idx + 1; f_x1 = 3 * idx + 2; f_x2 = 3 * idx + 3;
            f_last = (idx == 15);
            rdy = f_ready;
            if (f_level == 8 && !f_ready) saw_full = 1'b1;
            if (f_busy && !(f_level == 7 || f_level == 8)) bad++;
            @(negedge clk);
            n++;
            if (rdy) idx++;
        end
        f_valid = 1'b0; f_last = 1'b0;
        chk("t3_pushed", idx, 16);
        chk("t3_full_seen", saw_full, 1);
        chk("t3_level_range_bad", bad, 0);
        n = 0;
        while ((f_busy || f_level != 0) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("t3_tmo", n, 0);
        idle(LAT + 4);
        chk("t3_yn", fyq.size(), 19);
        for (int i = 0; i < 19 && i < fyq.size(); i++)
            chk($sformatf("t3_y0[%0d]", i), fyq[i], (i < 16) ? 3 * i + 1 : 0);
        chk("t3_undr", f_underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_stream_scheduler.md
# fir_stream_scheduler

Rate-matching scheduler that sits in front of the 3-parallel low-pass FIR filter (`x_in/x_in1/x_in2` in, `y_out/y_out1/y_out2` out). The filter has no enable, so it must be fed one 3-sample block on every clock. This block provides that feed:

- buffers incoming blocks in a FIFO;
- starts a frame only once enough blocks are buffered;
- streams one block per cycle to the filter;
- appends zero tail blocks to flush the filter taps at frame end;
- tags the filter outputs with valid/last, aligned to the filter latency;
- flags underruns.

## Interface
- `DATA_W`, 32, input sample width (signed)
- `OUT_W`, 64, filter output width (signed)
- `DEPTH`, 8, FIFO depth in blocks (power of 2, ≥2)
- `START_THRESH`, 4, buffered blocks required to start a frame (1..DEPTH)
- `TAIL_BLOCKS`, 3, zero blocks issued after the last block of a frame (≥1)
- `FILT_LAT`, 2, filter latency in clocks, from `x_in*` register load to `y_out*` valid (≥1)
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input block valid
- `s_ready` out 1: FIFO can accept a block
- `s_x0`, `s_x1`, `s_x2` in DATA_W each: input block; `s_x0` is the oldest sample
- `s_last` in 1: this block ends the frame
- `filt_x0`, `filt_x1`, `filt_x2` out DATA_W each: to filter `x_in`, `x_in1`, `x_in2`
- `filt_y0`, `filt_y1`, `filt_y2` in OUT_W each: from filter `y_out`, `y_out1`, `y_out2`
- `m_valid` out 1: `m_y*` carry filter results for an issued block
- `m_last` out 1: `m_y*` belong to the final tail block of a frame
- `m_y0`, `m_y1`, `m_y2` out OUT_W each: registered `filt_y*`
- `busy` out 1: state ≠ IDLE
- `underrun` out 1: sticky; set when the FIFO is empty in RUN
- `level` out $clog2(DEPTH)+1: FIFO occupancy in blocks

## Operation
**FIFO**
- Each entry is {`s_last`, `s_x2`, `s_x1`, `s_x0`}.
- Push happens when `s_valid && s_ready`.
- `s_ready = (level < DEPTH)`, computed combinationally from the registered count. When full, `s_ready` stays 0 even if a pop happens in the same cycle.
- Simultaneous push and pop leaves `level` unchanged.

**State machine: IDLE, RUN, DRAIN**
- **IDLE**
  - Loads zeros into `filt_x*`.
  - Moves to RUN when `level >= START_THRESH`.
  - Also moves to RUN when a buffered block has `last` set and `level > 0` (short frame).
- **RUN**
  - Pops the head block every cycle and loads it into `filt_x*`; the issue flag is 1.
  - Moves to DRAIN when the popped block has `last` set.
  - If the FIFO is empty: loads zeros, sets the issue flag to 1, sets `underrun`, and stays in RUN. The frame continues with zero-stuffed samples.
- **DRAIN**
  - Loads zeros for `TAIL_BLOCKS` cycles, counted by the tail counter; the issue flag is 1.
  - The final tail cycle carries the last flag.
  - Then returns to IDLE. Pushes are still accepted during DRAIN.

**Output alignment**
- The {issue, last} pair travels through a shift register of depth `FILT_LAT`.
- `m_y* <= filt_y*` every cycle.
- `m_valid/m_last <= shift register output`.
- No output backpressure: the filter cannot stall.

**Arithmetic**
- No arithmetic on the data.
- `level` wraps nowhere: it saturates by construction because pushes are blocked when full.

## Timing
- **Reset:** state = IDLE, FIFO empty, `level = 0`, `s_ready = 1`, `filt_x* = 0`, `m_valid = m_last = 0`, `m_y* = 0`, `busy = 0`, `underrun = 0`, shift register cleared. A reset in RUN or DRAIN abandons the frame at once, and no `m_valid` is seen after reset.
- **Start:** push at edge E0 → `level = START_THRESH` visible after E0 → state = RUN after E1 → first `filt_x*` load at E2.
- **Issue to output:** a block loaded into `filt_x*` at edge Ek appears on `m_y*` with `m_valid = 1` after edge Ek+FILT_LAT+1.
- **Continuity:** from the first issue through the last tail block, the issue flag is 1 on every cycle. As a result, `m_valid` is contiguous for (frame blocks + underrun blocks + `TAIL_BLOCKS`) cycles.
- **RUN → DRAIN:** happens on the edge that pops the `last` block. DRAIN → IDLE happens on the edge that issues the final tail block.
- **Back-to-back frames:**
  - If the FIFO holds ≥`START_THRESH` blocks at DRAIN exit, IDLE lasts exactly 1 cycle, during which a zero block is issued with the issue flag = 0.
  - If `level = 0` in IDLE and `s_last` arrives with the first block, RUN starts two edges later.

## Test plan
1. **Basic frame.** Use `START_THRESH` = 4, `FILT_LAT` = 2, `TAIL_BLOCKS` = 3. Push 6 blocks {1,2,3}…{16,17,18}, with `s_last` on the 6th, at full rate. Required response:
   - `filt_x0` sequence: 1, 4, 7, 10, 13, 16, then 0, 0, 0.
   - `m_valid` high for exactly 9 contiguous cycles, starting 3 edges after the first load.
   - `m_last` set on the 9th cycle only.
   - `underrun` = 0.
2. **Underrun.** Push 4 blocks, wait 2 idle cycles, then push 1 block with `s_last`. Required response:
   - 2 zero blocks issued mid-frame, `underrun` = 1.
   - `m_valid` run length = 4 + 2 + 1 + 3 = 10.
3. **Full FIFO.** Use `DEPTH` = 8 and hold `s_valid` = 1 while in IDLE with `START_THRESH` = 8. Required response:
   - `level` reaches 8 and `s_ready` = 0.
   - In RUN, pop and push alternate with `level` held at 7–8.
   - No data lost or duplicated; compare the issued sequence against the pushed sequence.
4. **Short frame.** Push a single block {5,6,7} with `s_last`. Required response:
   - RUN starts despite `level` (1) < `START_THRESH`.
   - Issued sequence: 5, then 3 zero blocks.
   - `m_valid` run length = 4.
5. **Reset mid-frame.** Assert `rst` for 1 cycle during RUN with `level` = 3. Required response:
   - Next cycle: `level` = 0, `busy` = 0, `filt_x*` = 0, `underrun` = 0.
   - `m_valid` = 0 thereafter until a new frame.
6. **Back-to-back frames.** Push two 4-block frames with no gap. Required response:
   - Exactly one non-valid IDLE cycle between the frames' `m_valid` runs.
   - Both `m_last` pulses present.
